// File: rtl/nubus_pkg.sv
// NuBus card shared definitions: start codes, ACK status codes, FSM states and lane helpers.
package nubus_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [3:0] TMADN_WR_BYTE_3 = 4'b0000;
   localparam logic [3:0] TMADN_WR_BYTE_2 = 4'b0001;
   localparam logic [3:0] TMADN_WR_BYTE_1 = 4'b0010;
   localparam logic [3:0] TMADN_WR_BYTE_0 = 4'b0011;
   localparam logic [3:0] TMADN_WR_HALF_1 = 4'b0100;
   localparam logic [3:0] TMADN_WR_BLOCK  = 4'b0101;
   localparam logic [3:0] TMADN_WR_HALF_0 = 4'b0110;
   localparam logic [3:0] TMADN_WR_WORD   = 4'b0111;
   localparam logic [3:0] TMADN_RD_BYTE_3 = 4'b1000;
   localparam logic [3:0] TMADN_RD_BYTE_2 = 4'b1001;
   localparam logic [3:0] TMADN_RD_BYTE_1 = 4'b1010;
   localparam logic [3:0] TMADN_RD_BYTE_0 = 4'b1011;
   localparam logic [3:0] TMADN_RD_HALF_1 = 4'b1100;
   localparam logic [3:0] TMADN_RD_BLOCK  = 4'b1101;
   localparam logic [3:0] TMADN_RD_HALF_0 = 4'b1110;
   localparam logic [3:0] TMADN_RD_WORD   = 4'b1111;

   localparam logic [1:0] TM_COMPLETE  = 2'b11;
   localparam logic [1:0] TM_ERROR     = 2'b10;
   localparam logic [1:0] TM_TIMEOUT   = 2'b01;
   localparam logic [1:0] TM_TRY_AGAIN = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ACK  = 2'd2
   } nub_state_e;

   // Byte strobes for a start code; read/write bit is ignored.
   function automatic logic [STRB_W-1:0] lane_mask(input logic [3:0] code);
      logic [STRB_W-1:0] m;
      case (code[2:0])
         TMADN_WR_BYTE_3[2:0]: m = 4'b1000;
         TMADN_WR_BYTE_2[2:0]: m = 4'b0100;
         TMADN_WR_BYTE_1[2:0]: m = 4'b0010;
         TMADN_WR_BYTE_0[2:0]: m = 4'b0001;
         TMADN_WR_HALF_1[2:0]: m = 4'b1100;
         TMADN_WR_HALF_0[2:0]: m = 4'b0011;
         default:              m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic is_block(input logic [3:0] code);
      return code[2:0] == TMADN_WR_BLOCK[2:0];
   endfunction

   function automatic logic is_read(input logic [3:0] code);
      return code[3];
   endfunction

endpackage

// File: rtl/nubus_card_ram.sv
// Card RAM, byte-strobe writes on the sampling edge; per-word valid bits make a one-cycle clear read as zero.
module nubus_card_ram
   import nubus_pkg::*;
#(
   parameter int unsigned AW = 10
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata_c
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic [DATA_W-1:0] bmask;

   assign bmask   = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
   assign rdata_c = vld[idx] ? mem[idx] : '0;

   always_ff @(negedge clk) begin
      if (clr) begin
         vld <= '0;
      end else if (we) begin
         vld[idx] <= 1'b1;
      end
   end

   // Merge keeps untouched lanes, which read as zero until the word is first written.
   always_ff @(negedge clk) begin
      if (we && !clr) begin
         mem[idx] <= (rdata_c & ~bmask) | (wdata & bmask);
      end
   end

endmodule

// File: rtl/nubus_card.sv
// NuBus slave card: slot decode, single-beat read/write into card RAM, one-clock ACK with status.
module nubus_card
   import nubus_pkg::*;
#(
   parameter int unsigned MEM_AW = 10
) (
   input  logic              nub_clkn,
   input  logic              nub_reset,
   input  logic [3:0]        nub_idn,
   input  logic              nub_pfwn,
   inout  wire  [DATA_W-1:0] nub_adn,
   inout  wire               nub_tm0n,
   inout  wire               nub_tm1n,
   inout  wire               nub_startn,
   inout  wire               nub_ackn,
   inout  wire               nub_rqstn,
   inout  wire  [3:0]        nub_arbn,
   output logic              nub_nmrqn,
   inout  wire               nub_spn,
   inout  wire               nub_spvn,
   input  logic              cpu_valid,
   input  logic [DATA_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [STRB_W-1:0] cpu_wstrb,
   input  logic              cpu_lock,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata
);

   nub_state_e        state_q, state_d;
   logic [3:0]        code_q, code_d;
   logic [MEM_AW-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ram_clr_q;
   logic              ram_we_c;
   logic [DATA_W-1:0] ram_rdata_c;

   logic [DATA_W-1:0] addr_c;
   logic [3:0]        code_c;
   logic              myslot_c;

   logic              ack_oe_q;
   logic              data_oe_q;
   logic [1:0]        status_q;
   logic [DATA_W-1:0] dout_q;

   assign addr_c   = ~nub_adn;
   assign code_c   = {nub_tm1n, nub_tm0n, nub_adn[1], nub_adn[0]};
   assign myslot_c = addr_c[31:24] == {4'hF, ~nub_idn};

   // Sampling side: falling edge of the NuBus clock.
   always_ff @(negedge nub_clkn or posedge nub_reset) begin
      if (nub_reset) begin
         state_q   <= ST_IDLE;
         code_q    <= '0;
         idx_q     <= '0;
         rdata_q   <= '0;
         ram_clr_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         idx_q     <= idx_d;
         rdata_q   <= rdata_d;
         ram_clr_q <= 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      idx_d    = idx_q;
      rdata_d  = rdata_q;
      ram_we_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!nub_startn && myslot_c) begin
               code_d  = code_c;
               idx_d   = addr_c[MEM_AW+1:2];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            rdata_d  = ram_rdata_c;
            ram_we_c = !is_read(code_q) && !is_block(code_q);
            state_d  = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Driving side: rising edge; ACK state seen here yields exactly one driven clock.
   always_ff @(posedge nub_clkn or posedge nub_reset) begin
      if (nub_reset) begin
         ack_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         status_q  <= TM_COMPLETE;
         dout_q    <= '0;
      end else begin
         ack_oe_q  <= state_q == ST_ACK;
         data_oe_q <= (state_q == ST_ACK) && is_read(code_q);
         status_q  <= is_block(code_q) ? TM_ERROR : TM_COMPLETE;
         dout_q    <= rdata_q;
      end
   end

   nubus_card_ram #(.AW(MEM_AW)) u_ram (
      .clk     (nub_clkn),
      .clr     (ram_clr_q),
      .we      (ram_we_c),
      .idx     (idx_q),
      .wstrb   (lane_mask(code_q)),
      .wdata   (addr_c),
      .rdata_c (ram_rdata_c)
   );

   assign nub_ackn   = ack_oe_q  ? 1'b0        : 1'bz;
   assign nub_tm1n   = ack_oe_q  ? status_q[1] : 1'bz;
   assign nub_tm0n   = ack_oe_q  ? status_q[0] : 1'bz;
   assign nub_adn    = data_oe_q ? ~dout_q     : {DATA_W{1'bz}};
   assign nub_rqstn  = 1'bz;
   assign nub_arbn   = 4'bzzzz;
   assign nub_nmrqn  = 1'bz;
   assign nub_spn    = 1'bz;
   assign nub_spvn   = 1'bz;

   // Idle master-side outputs.
   assign cpu_ready  = 1'b0;
   assign cpu_rdata  = '0;

   logic unused_c;
   assign unused_c = ^{nub_pfwn, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, cpu_lock,
                       nub_ackn, nub_rqstn, nub_arbn, nub_spn, nub_spvn};

endmodule

// File: tb/tb_nubus_card.sv
// Directed plus randomized NuBus slave transfers checked against a word-array model of the card RAM.
module tb_nubus_card;

   logic        nub_clkn;
   logic        nub_reset;
   logic [3:0]  nub_idn;
   logic        nub_pfwn;
   wire  [31:0] nub_adn;
   wire         nub_tm0n, nub_tm1n, nub_startn, nub_ackn, nub_rqstn, nub_nmrqn, nub_spn, nub_spvn;
   wire  [3:0]  nub_arbn;
   logic        cpu_valid, cpu_lock;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;

   logic        m_start_oe, m_adn_oe, m_tm_oe;
   logic [31:0] m_adn;
   logic [1:0]  m_tm;

   int          n_cmp, n_err;
   int unsigned slot;
   logic [31:0] ref_mem [1024];
   logic [31:0] rd;

   assign nub_startn = m_start_oe ? 1'b0    : 1'bz;
   assign nub_adn    = m_adn_oe   ? m_adn   : {32{1'bz}};
   assign nub_tm1n   = m_tm_oe    ? m_tm[1] : 1'bz;
   assign nub_tm0n   = m_tm_oe    ? m_tm[0] : 1'bz;

   pullup (nub_startn);
   pullup (nub_ackn);
   pullup (nub_tm0n);
   pullup (nub_tm1n);
   for (genvar g = 0; g < 32; g++) begin : g_pu
      pullup (nub_adn[g]);
   end

   nubus_card #(.MEM_AW(10)) dut (
      .nub_clkn   (nub_clkn),
      .nub_reset  (nub_reset),
      .nub_idn    (nub_idn),
      .nub_pfwn   (nub_pfwn),
      .nub_adn    (nub_adn),
      .nub_tm0n   (nub_tm0n),
      .nub_tm1n   (nub_tm1n),
      .nub_startn (nub_startn),
      .nub_ackn   (nub_ackn),
      .nub_rqstn  (nub_rqstn),
      .nub_arbn   (nub_arbn),
      .nub_nmrqn  (nub_nmrqn),
      .nub_spn    (nub_spn),
      .nub_spvn   (nub_spvn),
      .cpu_valid  (cpu_valid),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wstrb  (cpu_wstrb),
      .cpu_lock   (cpu_lock),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata)
   );

   always #10 nub_clkn = ~nub_clkn;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bits a start code writes, from the lane table.
   function automatic logic [31:0] lane_bits(input logic [3:0] code);
      case (code[2:0])
         3'd0:    return 32'hFF00_0000;
         3'd1:    return 32'h00FF_0000;
         3'd2:    return 32'h0000_FF00;
         3'd3:    return 32'h0000_00FF;
         3'd4:    return 32'hFFFF_0000;
         3'd6:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
   endtask

   // One 10-clock bus window: start in clock 0, data in clock 1, observe every clock mid-high-phase.
   task automatic xfer(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int nlow, output logic [1:0] st,
                       output logic [31:0] rdat, output logic idle_ok);
      lat = -1; nlow = 0; st = 2'b00; rdat = 32'h0; idle_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge nub_clkn); #1;
         if (k == 0) begin
            m_start_oe = 1'b1; m_adn_oe = 1'b1; m_tm_oe = 1'b1;
            m_adn = {~addr[31:2], code[1:0]};
            m_tm  = code[3:2];
         end else if (k == 1) begin
            m_start_oe = 1'b0; m_tm_oe = 1'b0;
            m_adn_oe = !code[3];
            m_adn = ~wdata;
         end else begin
            m_adn_oe = 1'b0;
         end
         #4;
         if (nub_ackn == 1'b0) begin
            if (lat < 0) begin
               lat  = k;
               st   = {nub_tm1n, nub_tm0n};
               rdat = ~nub_adn;
            end
            nlow++;
         end else if (k >= 2) begin
            if (nub_adn !== 32'hFFFF_FFFF || nub_tm1n !== 1'b1 || nub_tm0n !== 1'b1) idle_ok = 1'b0;
         end
      end
   endtask

   task automatic txn(input string tag, input logic [3:0] code, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdat);
      int          lat, nlow;
      logic [1:0]  st;
      logic        idle_ok, hit;
      int unsigned idx;
      logic [31:0] m;
      xfer(code, addr, wdata, lat, nlow, st, rdat, idle_ok);
      hit = addr[31:24] == {4'hF, 4'(slot)};
      idx = (addr / 4) % 1024;
      check({tag, ".bus_released"}, 32'(idle_ok), 32'd1);
      if (hit) begin
         check({tag, ".ack_latency"}, 32'(lat), 32'd2);
         check({tag, ".ack_clocks"}, 32'(nlow), 32'd1);
         check({tag, ".status"}, 32'(st), (code[2:0] == 3'd5) ? 32'd2 : 32'd3);
         if (code[3]) begin
            check({tag, ".rdata"}, rdat, ref_mem[idx]);
         end else if (code[2:0] != 3'd5) begin
            m = lane_bits(code);
            ref_mem[idx] = (ref_mem[idx] & ~m) | (wdata & m);
         end
      end else begin
         check({tag, ".no_ack"}, 32'(lat), 32'hFFFF_FFFF);
      end
   endtask

   initial begin
      logic        ack_seen;
      logic [3:0]  code;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        hit;
      n_cmp = 0; n_err = 0;
      nub_clkn = 1'b0; nub_reset = 1'b0; nub_pfwn = 1'b1;
      slot = 0; nub_idn = 4'hF;
      m_start_oe = 1'b0; m_adn_oe = 1'b0; m_tm_oe = 1'b0; m_adn = '0; m_tm = '0;
      cpu_valid = 1'b1; cpu_lock = 1'b1; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'hF;
      clear_model();

      #2 nub_reset = 1'b1;
      repeat (3) @(posedge nub_clkn);
      #5;
      check("reset.ackn", 32'(nub_ackn), 32'd1);
      check("reset.adn", nub_adn, 32'hFFFF_FFFF);
      check("reset.cpu_ready", 32'(cpu_ready), 32'd0);
      check("reset.cpu_rdata", cpu_rdata, 32'd0);
      @(posedge nub_clkn); #1 nub_reset = 1'b0;

      txn("wr_word", 4'h7, 32'hF000_0000, 32'h8765_4321, rd);
      txn("rd_word", 4'hF, 32'hF000_0000, 32'h0, rd);
      check("rd_word.lit", rd, 32'h8765_4321);

      txn("wr_half0", 4'h6, 32'hF000_0004, 32'h8765_4321, rd);
      txn("rd_half0", 4'hE, 32'hF000_0004, 32'h0, rd);
      check("rd_half0.lit", rd, 32'h0000_4321);
      txn("wr_half1", 4'h4, 32'hF000_0008, 32'h8765_4321, rd);
      txn("rd_half1", 4'hC, 32'hF000_0008, 32'h0, rd);
      check("rd_half1.lit", rd, 32'h8765_0000);

      txn("wr_byte0", 4'h3, 32'hF000_000C, 32'h8765_4321, rd);
      txn("wr_byte1", 4'h2, 32'hF000_0010, 32'h8765_4321, rd);
      txn("wr_byte2", 4'h1, 32'hF000_0014, 32'h8765_4321, rd);
      txn("wr_byte3", 4'h0, 32'hF000_0018, 32'h8765_4321, rd);
      txn("rd_byte0", 4'hB, 32'hF000_000C, 32'h0, rd);
      check("rd_byte0.lit", rd, 32'h0000_0021);
      txn("rd_byte1", 4'hA, 32'hF000_0010, 32'h0, rd);
      check("rd_byte1.lit", rd, 32'h0000_4300);
      txn("rd_byte2", 4'h9, 32'hF000_0014, 32'h0, rd);
      check("rd_byte2.lit", rd, 32'h0065_0000);
      txn("rd_byte3", 4'h8, 32'hF000_0018, 32'h0, rd);
      check("rd_byte3.lit", rd, 32'h8700_0000);

      txn("other_slot", 4'h7, 32'hF100_0000, 32'h55AA_55AA, rd);

      txn("wr_block", 4'h5, 32'hF000_0000, 32'h1234_5678, rd);
      txn("rd_after_block", 4'hF, 32'hF000_0000, 32'h0, rd);
      check("rd_after_block.lit", rd, 32'h8765_4321);

      // Reset asserted in the DATA clock of a write, before the sampling edge.
      ack_seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge nub_clkn); #1;
         if (k == 0) begin
            m_start_oe = 1'b1; m_adn_oe = 1'b1; m_tm_oe = 1'b1;
            m_adn = {~30'(32'hF000_0020 >> 2), 2'b11};
            m_tm  = 2'b01;
         end else if (k == 1) begin
            m_start_oe = 1'b0; m_tm_oe = 1'b0; m_adn = ~32'hDEAD_BEEF;
         end else begin
            m_adn_oe = 1'b0;
         end
         if (k == 4) nub_reset = 1'b0;
         #4;
         if (k == 1) nub_reset = 1'b1;
         if (nub_ackn == 1'b0) ack_seen = 1'b1;
      end
      check("reset_mid_write.no_ack", 32'(ack_seen), 32'd0);
      clear_model();
      txn("rd_after_reset", 4'hF, 32'hF000_0020, 32'h0, rd);
      check("rd_after_reset.lit", rd, 32'h0);
      txn("rd_cleared", 4'hF, 32'hF000_0000, 32'h0, rd);
      check("rd_cleared.lit", rd, 32'h0);

      for (int n = 0; n < 60; n++) begin
         if ((n % 10) == 0) begin
            slot = $urandom_range(0, 15);
            nub_idn = ~4'(slot);
         end
         hit  = $urandom_range(0, 5) != 0;
         code = 4'($urandom_range(0, 15));
         if (code == 4'hD) code = 4'hF;
         addr = {4'hF, hit ? 4'(slot) : 4'(slot + 1), 24'($urandom) & 24'hFFF03C};
         if (!hit && ($urandom_range(0, 1) == 1)) addr[31:28] = 4'hE;
         wdata = $urandom;
         txn("rand", code, addr, wdata, rd);
      end

      check("end.cpu_ready", 32'(cpu_ready), 32'd0);
      check("end.cpu_rdata", cpu_rdata, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
